// File: rtl/demux1t2_32_buf.sv
// Registered 1-to-2 word demultiplexer. Each output has a single-entry
// holding register with a valid/ready handshake and a transfer counter.
module demux1t2_32_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] out0_count,
    output logic [CNT_W-1:0] out1_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t state0;
    slot_state_t state1;
    logic        room0;
    logic        room1;
    logic        fill0;
    logic        fill1;
    logic        drain0;
    logic        drain1;

    assign out0_valid = (state0 == FULL);
    assign out1_valid = (state1 == FULL);

    assign drain0 = out0_valid && out0_ready;
    assign drain1 = out1_valid && out1_ready;

    // A slot has room when it is empty or is being emptied this cycle.
    assign room0    = !out0_valid || out0_ready;
    assign room1    = !out1_valid || out1_ready;
    assign in_ready = in_sel ? room1 : room0;

    assign fill0 = in_valid && in_ready && !in_sel;
    assign fill1 = in_valid && in_ready && in_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0     <= EMPTY;
            out0_data  <= '0;
            out0_count <= '0;
        end else begin
            if (fill0) begin
                state0    <= FULL;
                out0_data <= in_data;
            end else if (drain0) begin
                state0 <= EMPTY;
            end
            if (drain0) begin
                out0_count <= out0_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state1     <= EMPTY;
            out1_data  <= '0;
            out1_count <= '0;
        end else begin
            if (fill1) begin
                state1    <= FULL;
                out1_data <= in_data;
            end else if (drain1) begin
                state1 <= EMPTY;
            end
            if (drain1) begin
                out1_count <= out1_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/demux1t2_32_buf.md
Name: demux1t2_32_buf

Overview:
- Registered 1-to-2 demultiplexer for 32-bit datapath words: the distribution counterpart to the 2:1 word-select mux in the CPU datapath.
- One producer stream is steered by a per-word select bit to one of two consumer streams.
- Each output has a single-entry holding register with valid/ready handshake, so a stalled consumer back-pressures only words destined for it.
- Per-output transfer counters support debug and performance observation.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 8, width of each per-output transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  producer word.
- in_sel  input  1  destination: 0 = out0, 1 = out1; sampled with in_data.
- out0_valid  output  1  out0 register holds a word.
- out0_ready  input  1  consumer 0 takes the word.
- out0_data  output  WIDTH  out0 word.
- out1_valid  output  1  out1 register holds a word.
- out1_ready  input  1  consumer 1 takes the word.
- out1_data  output  WIDTH  out1 word.
- out0_count  output  CNT_W  completed out0 handshakes.
- out1_count  output  CNT_W  completed out1 handshakes.

Behaviour:
- Reset: rst_n low clears state asynchronously. Resulting values: outN_valid = 0, outN_data = 0, outN_count = 0.
- Reset mid-operation: buffered words are discarded.
- First active edge after rst_n rises: normal operation.
- Per-output state, single bit outN_valid:
  - EMPTY (0) -> FULL (1) on a fill.
  - FULL -> EMPTY on a drain without a fill.
  - FULL -> FULL on a simultaneous drain and fill.
- Fill of output N: in_valid && in_ready && in_sel == N. At the next edge, outN_data <= in_data and outN_valid <= 1.
- Drain of output N: outN_valid && outN_ready.
- in_ready = (!outN_valid || outN_ready), with N = in_sel. This is combinational and must not depend on in_valid.
- outN_valid and outN_data are registered only and never depend on outN_ready combinationally.
- Latency: an accepted word appears at the selected output on the cycle after acceptance.
- Throughput: one word per cycle into either output while that output's ready is held high.
- Stall: while outN_valid && !outN_ready, outN_data and outN_valid hold. Input words selecting N are refused (in_ready = 0).
  - A word selecting the other output is still accepted if that output has room.
- Simultaneous drain and fill on the same output: valid stays 1, data is replaced by the new word, and the drain is counted.
- The non-selected output is never modified by an input transfer.
- outN_data is not cleared on drain; it keeps its last value while valid = 0.
- Counters:
  - outN_count increments by 1 on each drain of output N.
  - Wrap from 2^CNT_W-1 to 0 with no saturation or flag.
  - Both counters may increment in the same cycle.
- Ordering: words to the same output leave in acceptance order. Nothing is guaranteed across outputs.
- No word is duplicated or lost except by reset.
- in_sel is ignored when in_valid = 0. An X on in_sel while in_valid = 1 is a protocol violation; the bench asserts against it.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 2 cycles, then released; in_valid = 0.
  - Required: all valids 0, data 0, counts 0, in_ready = 1 for both sel values.
- Single routed word:
  - Stimulus: in_data = 32'hDEADBEEF, in_sel = 1, in_valid for 1 cycle; out1_ready = 1.
  - Required: out1_valid high for exactly 1 cycle, one cycle later, with out1_data = DEADBEEF. out0_valid stays 0. out1_count = 1.
- Back-pressure isolation:
  - Stimulus: out0_ready = 0; send A (sel 0), then B (sel 0), then C (sel 1).
  - Required: A held on out0 and in_ready = 0 while B is presented. Then present C instead of B: C is accepted and delivered on out1. Raise out0_ready: A drains, then B is accepted next.
- Full throughput:
  - Stimulus: both readies = 1; 16 back-to-back words with alternating sel, values 1..16.
  - Required: odd values on out0 and even values on out1, in order, with no bubbles. Both counts = 8.
- Drain and fill in the same cycle:
  - Stimulus: out0 holds 32'h11; in the same cycle out0_ready = 1 and a new word 32'h22 with sel 0 is presented.
  - Required: in_ready = 1 that cycle; next cycle out0_valid = 1 and out0_data = 22; out0_count has incremented by 1.
- Counter wrap and async reset:
  - Stimulus: with CNT_W = 4, perform 17 out1 transfers, then pulse rst_n low between clock edges while out0 is FULL.
  - Required: out1_count = 1 after the 17 transfers. On the reset pulse, valids and counts drop to 0 immediately, without waiting for a clock edge.
